// File: rtl/gmii_frame_arbiter.sv
// Store-and-forward merge of NUM_PORTS GMII inputs onto one GMII output, whole frames,
// round-robin, with an IFG gap. Define GMII_ARB_ERR_DROP_EN to discard frames containing in_er.
module gmii_frame_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int DEPTH     = 2048,
  parameter int IFG       = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   in_dv,
  input  logic [NUM_PORTS-1:0]   in_er,
  input  logic [8*NUM_PORTS-1:0] in_data,
  output logic                   out_dv,
  output logic                   out_er,
  output logic [7:0]             out_data,
  output logic [NUM_PORTS-1:0]   drop,
  output logic [1:0]             dbg_state
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int PW    = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  logic [9:0]           rd_word [NUM_PORTS];
  logic [NUM_PORTS-1:0] rd_en;
  logic [NUM_PORTS-1:0] cnt_dec;
  logic [NUM_PORTS-1:0] has_frame;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [9:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, frame_start, occ, cnt;
    logic             dv_q, er_q, armed, bad, drop_q;
    logic [7:0]       data_q;
    logic             full, wr_need, at_end, frame_err, abort, wr_en, commit, er_store;

    assign occ     = wr_ptr - rd_ptr;
    assign full    = (occ == PTR_W'(DEPTH));
    assign wr_need = dv_q & ~bad;
    assign at_end  = dv_q & ~in_dv[p];
`ifdef GMII_ARB_ERR_DROP_EN
    logic err_seen;
    assign frame_err = at_end & (err_seen | er_q);
    assign er_store  = 1'b0;
`else
    assign frame_err = 1'b0;
    assign er_store  = er_q;
`endif
    assign abort  = wr_need & (full | frame_err);
    assign wr_en  = wr_need & ~abort;
    assign commit = wr_en & at_end;

    assign rd_word[p]   = mem[rd_ptr[AW-1:0]];
    assign has_frame[p] = (cnt != '0);
    assign drop[p]      = drop_q;

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {at_end, er_store, data_q};
    end

    // armed stays low after reset until dv is seen low, so a frame already
    // in flight at reset release is never captured.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        frame_start <= '0;
        cnt         <= '0;
        dv_q        <= 1'b0;
        er_q        <= 1'b0;
        data_q      <= '0;
        armed       <= 1'b0;
        bad         <= 1'b0;
        drop_q      <= 1'b0;
      end else begin
        armed  <= armed | ~in_dv[p];
        dv_q   <= in_dv[p] & armed;
        er_q   <= in_er[p];
        data_q <= in_data[8*p +: 8];
        drop_q <= 1'b0;
        if (wr_en)  wr_ptr <= wr_ptr + PTR_W'(1);
        if (abort)  wr_ptr <= frame_start;
        if (commit) frame_start <= wr_ptr + PTR_W'(1);
        if (at_end) begin
          bad <= 1'b0;
          if (abort | bad) drop_q <= 1'b1;
        end else if (abort) begin
          bad <= 1'b1;
        end
        if (rd_en[p]) rd_ptr <= rd_ptr + PTR_W'(1);
        cnt <= cnt + PTR_W'(commit) - PTR_W'(cnt_dec[p]);
      end
    end

`ifdef GMII_ARB_ERR_DROP_EN
    always_ff @(posedge clk) begin
      if (rst || at_end) err_seen <= 1'b0;
      else if (dv_q && er_q) err_seen <= 1'b1;
    end
`endif
  end

  state_t          state, state_nx;
  logic [PW-1:0]   grant, grant_nx, last_grant, last_grant_nx, pick, sel_port, idx;
  logic            pick_ok;
  logic [7:0]      gap_cnt, gap_nx;
  logic [9:0]      word;
  logic            rd_v, rd_v_q;
  logic [8:0]      rd_q;

  // Scan from the highest offset down so the first nonzero port after last_grant wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = PW'((int'(last_grant) + i) % NUM_PORTS);
      if (has_frame[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  assign sel_port  = (state == S_IDLE) ? pick : grant;
  assign word      = rd_word[sel_port];
  assign dbg_state = state;

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    gap_nx        = gap_cnt;
    rd_v          = 1'b0;
    rd_en         = '0;
    cnt_dec       = '0;
    case (state)
      S_IDLE: begin
        if (pick_ok) begin
          rd_v          = 1'b1;
          rd_en[pick]   = 1'b1;
          grant_nx      = pick;
          last_grant_nx = pick;
          if (word[9]) begin
            cnt_dec[pick] = 1'b1;
            gap_nx        = '0;
            state_nx      = S_GAP;
          end else begin
            state_nx = S_SEND;
          end
        end
      end
      S_SEND: begin
        rd_v         = 1'b1;
        rd_en[grant] = 1'b1;
        if (word[9]) begin
          cnt_dec[grant] = 1'b1;
          gap_nx         = '0;
          state_nx       = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == 8'(IFG - 1)) state_nx = S_IDLE;
        else gap_nx = gap_cnt + 8'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
      gap_cnt    <= '0;
      rd_v_q     <= 1'b0;
      rd_q       <= '0;
      out_dv     <= 1'b0;
      out_er     <= 1'b0;
      out_data   <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      gap_cnt    <= gap_nx;
      rd_v_q     <= rd_v;
      rd_q       <= rd_v ? word[8:0] : 9'd0;
      out_dv     <= rd_v_q;
      out_er     <= rd_v_q & rd_q[8];
      out_data   <= rd_v_q ? rd_q[7:0] : 8'd0;
    end
  end

endmodule
